// File: rtl/fsser_pkg.sv
// Shared constants and state types for the fast opto-isolated serial link.
package fsser_pkg;

    localparam int unsigned FSSER_FRAME_BITS = 10;
    localparam int unsigned FSSER_DATA_BITS  = 8;

    localparam logic FSSER_START_BIT  = 1'b0;
    localparam logic FSSER_IDLE_LEVEL = 1'b1;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

endpackage

// File: rtl/fsser_edge_sync.sv
// Synchronizes FSCLK/FSDI into the system clock domain and produces
// one-cycle rise/fall pulses with FSDI delayed by the same depth.
module fsser_edge_sync
    import fsser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic sdi_i,
    output logic rise_o,
    output logic fall_o,
    output logic sdi_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sclk_prev_q;

    // Synchronizer chains plus the previous synchronized clock level.
    // FSDI resets to the idle level so no phantom start bit is seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q      <= '0;
            sdi_q       <= {SYNC_STAGES{FSSER_IDLE_LEVEL}};
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            sdi_q       <= {sdi_q[SYNC_STAGES-2:0], sdi_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign sdi_o  = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/fsser_target.sv
// Target side of the fast opto-isolated serial link: receives frames on
// FSDI, transmits frames on FSDO, exposes byte streams in the wb_clk domain.
// Optional macro FSSER_OVERRUN_EN adds a sticky overrun flag and drop counter.
module fsser_target
    import fsser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        TX_SRC      = 1'b0
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       i_fsclk,
    input  logic       i_fsdi,
    output logic       o_fsdo,
    output logic       o_fscts,
    output logic [7:0] o_rx_data,
    output logic       o_rx_src,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready
`ifdef FSSER_OVERRUN_EN
    ,
    output logic        o_overrun,
    input  logic        i_overrun_clr,
    output logic [15:0] o_drop_cnt
`endif
);

    logic rise, fall, sdi;

    fsser_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk),
        .rst_i (wb_rst),
        .sclk_i(i_fsclk),
        .sdi_i (i_fsdi),
        .rise_o(rise),
        .fall_o(fall),
        .sdi_o (sdi)
    );

    // ---------------- RX path ----------------
    rx_state_e  rx_state_q, rx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [8:0] rx_sr_q, rx_sr_d;
    logic       rx_done;
    logic       full_q, full_d;
    logic [7:0] data_q, data_d;
    logic       src_q, src_d;
    logic       fscts_q;
    logic       pop, load;

    // RX next state: wait for a start bit, then shift 8 data bits + source.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rise && sdi == FSSER_START_BIT) begin
                    rx_state_d = RX_SHIFT;
                    rx_cnt_d   = '0;
                end
            end
            RX_SHIFT: begin
                if (rise) begin
                    rx_sr_d = {sdi, rx_sr_q[8:1]};
                    if (rx_cnt_q == 4'(FSSER_DATA_BITS)) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Holding register: a pop in the same cycle as a load frees the slot.
    always_comb begin
        pop    = full_q & i_rx_ready;
        load   = rx_done & (~full_q | pop);
        full_d = load ? 1'b1 : (pop ? 1'b0 : full_q);
        data_d = load ? rx_sr_d[7:0] : data_q;
        src_d  = load ? rx_sr_d[8] : src_q;
    end

    // RX state, shifter and holding register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            full_q     <= 1'b0;
            data_q     <= '0;
            src_q      <= 1'b0;
            fscts_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sr_q    <= rx_sr_d;
            full_q     <= full_d;
            data_q     <= data_d;
            src_q      <= src_d;
            fscts_q    <= ~full_d;
        end
    end

    assign o_rx_valid = full_q;
    assign o_rx_data  = data_q;
    assign o_rx_src   = src_q;
    assign o_fscts    = fscts_q;

`ifdef FSSER_OVERRUN_EN
    logic        drop;
    logic        overrun_q;
    logic [15:0] drop_cnt_q;

    assign drop = rx_done & full_q & ~pop;

    // Sticky overrun flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (drop)               overrun_q <= 1'b1;
            else if (i_overrun_clr) overrun_q <= 1'b0;
            if (i_overrun_clr)           drop_cnt_q <= drop ? 16'd1 : 16'd0;
            else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign o_overrun  = overrun_q;
    assign o_drop_cnt = drop_cnt_q;
`endif

    // ---------------- TX path ----------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [9:0] tx_sr_q, tx_sr_d;
    logic       fsdo_q, fsdo_d;
    logic       tx_ready_q, tx_ready_d;

    // TX next state: latch a frame, emit one bit per fall, then one idle bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sr_d    = tx_sr_q;
        fsdo_d     = fsdo_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (i_tx_valid && tx_ready_q) begin
                    tx_sr_d    = {TX_SRC, i_tx_data, FSSER_START_BIT};
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (fall) begin
                    if (tx_cnt_q == 4'(FSSER_FRAME_BITS)) begin
                        fsdo_d     = FSSER_IDLE_LEVEL;
                        tx_state_d = TX_IDLE;
                    end else begin
                        fsdo_d   = tx_sr_q[0];
                        tx_sr_d  = {FSSER_IDLE_LEVEL, tx_sr_q[9:1]};
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_ready_d = (tx_state_d == TX_IDLE);
    end

    // TX state, shifter and registered line/ready outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_sr_q    <= '0;
            fsdo_q     <= FSSER_IDLE_LEVEL;
            tx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sr_q    <= tx_sr_d;
            fsdo_q     <= fsdo_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign o_fsdo     = fsdo_q;
    assign o_tx_ready = tx_ready_q;

endmodule

// File: tb/tb_fsser_target.sv
// Self-checking bench for fsser_target acting as the serial master.
module tb_fsser_target;

    localparam int H = 4;  // FSCLK half period in wb_clk cycles

    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic       i_fsclk = 1'b0;
    logic       i_fsdi = 1'b1;
    logic       o_fsdo, o_fscts, o_rx_src, o_rx_valid, o_tx_ready;
    logic [7:0] o_rx_data;
    logic       i_rx_ready = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic       i_tx_valid = 1'b0;
`ifdef FSSER_OVERRUN_EN
    logic        o_overrun;
    logic        i_overrun_clr = 1'b0;
    logic [15:0] o_drop_cnt;
`endif

    int total = 0;
    int bad = 0;
    int rx_lat = 3;
    int valid_rises = 0;
    logic prev_valid = 1'b0;

    always #5 wb_clk = ~wb_clk;

    fsser_target #(
        .SYNC_STAGES(2),
        .TX_SRC(1'b1)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_fsclk   (i_fsclk),
        .i_fsdi    (i_fsdi),
        .o_fsdo    (o_fsdo),
        .o_fscts   (o_fscts),
        .o_rx_data (o_rx_data),
        .o_rx_src  (o_rx_src),
        .o_rx_valid(o_rx_valid),
        .i_rx_ready(i_rx_ready),
        .i_tx_data (i_tx_data),
        .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready)
`ifdef FSSER_OVERRUN_EN
        ,
        .o_overrun    (o_overrun),
        .i_overrun_clr(i_overrun_clr),
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    // Counts rising edges of o_rx_valid.
    always @(posedge wb_clk) begin
        prev_valid <= o_rx_valid;
        if (o_rx_valid && !prev_valid) valid_rises <= valid_rises + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    // Frame bit i: start 0, data LSB first, then source.
    function automatic logic frame_bit(input logic [7:0] d, input logic s, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        return s;
    endfunction

    task automatic clk_bit_hi(input logic di, output logic so);
        @(negedge wb_clk);
        i_fsclk = 1'b0;
        i_fsdi  = di;
        repeat (H) @(negedge wb_clk);
        so      = o_fsdo;
        i_fsclk = 1'b1;
    endtask

    task automatic clk_bit(input logic di, output logic so);
        clk_bit_hi(di, so);
        repeat (H - 1) @(negedge wb_clk);
    endtask

    task automatic park();
        @(negedge wb_clk);
        i_fsclk = 1'b0;
        i_fsdi  = 1'b1;
        repeat (2 * H) @(negedge wb_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic s);
        logic so;
        for (int i = 0; i < 10; i++) clk_bit(frame_bit(d, s, i), so);
        park();
    endtask

    task automatic pop(input string name);
        @(negedge wb_clk);
        i_rx_ready = 1'b1;
        @(negedge wb_clk);
        i_rx_ready = 1'b0;
        total++;
        if ({o_rx_valid, o_fscts} !== 2'b01) begin
            bad++;
            $display("FAIL %s_pop: valid,cts=%b want 01", name, {o_rx_valid, o_fscts});
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] d, input logic s);
        total++;
        if ({o_rx_valid, o_fscts, o_rx_src, o_rx_data} !== {2'b10, s, d}) begin
            bad++;
            $display("FAIL %s_rx: valid,cts,src,data=%b,%b,%b,%h want 1,0,%b,%h",
                     name, o_rx_valid, o_fscts, o_rx_src, o_rx_data, s, d);
        end
    endtask

    task automatic tx_offer(input logic [7:0] d, input string name);
        int n;
        n = 0;
        while (!o_tx_ready && n < 100) begin
            @(negedge wb_clk);
            n++;
        end
        total++;
        if (!o_tx_ready) begin
            bad++;
            $display("FAIL %s_ready_wait: tx_ready=%b want 1", name, o_tx_ready);
        end
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        @(negedge wb_clk);
        i_tx_valid = 1'b0;
        total++;
        if (o_tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_ready_drop: tx_ready=%b want 0", name, o_tx_ready);
        end
    endtask

    // 12 FSCLK cycles from low idle; optionally carries an RX frame in cycles 2..11.
    task automatic run_cycles(input logic rx_on, input logic [7:0] rd, input logic rs,
                              output logic [12:1] samp, output logic [12:1] rdy);
        logic so, di;
        for (int k = 1; k <= 12; k++) begin
            di = (rx_on && k >= 2 && k <= 11) ? frame_bit(rd, rs, k - 2) : 1'b1;
            clk_bit_hi(di, so);
            samp[k] = so;
            rdy[k]  = o_tx_ready;
            repeat (H - 1) @(negedge wb_clk);
        end
    endtask

    task automatic check_tx(input string name, input logic [7:0] d,
                            input logic [12:1] samp, input logic [12:1] rdy);
        logic [12:1] e;
        e[1] = 1'b1;
        for (int k = 2; k <= 11; k++) e[k] = frame_bit(d, 1'b1, k - 2);
        e[12] = 1'b1;
        total++;
        if (samp !== e) begin
            bad++;
            $display("FAIL %s_bits: fsdo samples=%b want %b", name, samp, e);
        end
        total++;
        if (rdy !== 12'b1000_0000_0000) begin
            bad++;
            $display("FAIL %s_ready_seq: tx_ready samples=%b want 100000000000", name, rdy);
        end
    endtask

    task automatic test_reset();
        wb_rst = 1'b1;
        repeat (3) @(negedge wb_clk);
        total++;
        if ({o_fsdo, o_fscts, o_rx_valid, o_tx_ready, o_rx_data, o_rx_src} !== 13'b1_0_0_0_00000000_0) begin
            bad++;
            $display("FAIL reset_state: fsdo,cts,valid,ready,data,src=%b,%b,%b,%b,%h,%b want 1,0,0,0,00,0",
                     o_fsdo, o_fscts, o_rx_valid, o_tx_ready, o_rx_data, o_rx_src);
        end
`ifdef FSSER_OVERRUN_EN
        total++;
        if ({o_overrun, o_drop_cnt} !== 17'd0) begin
            bad++;
            $display("FAIL reset_overrun: overrun=%b cnt=%0d want 0,0", o_overrun, o_drop_cnt);
        end
`endif
        wb_rst = 1'b0;
        @(negedge wb_clk);
        total++;
        if ({o_fscts, o_tx_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: cts,ready=%b want 11", {o_fscts, o_tx_ready});
        end
    endtask

    task automatic test_rx_single();
        logic so;
        int   r0;
        r0 = valid_rises;
        for (int i = 0; i < 9; i++) clk_bit(frame_bit(8'hA5, 1'b1, i), so);
        clk_bit_hi(frame_bit(8'hA5, 1'b1, 9), so);
        rx_lat = 0;
        while (!o_rx_valid && rx_lat < 20) begin
            @(negedge wb_clk);
            rx_lat++;
        end
        total++;
        if (!o_rx_valid) begin
            bad++;
            $display("FAIL rx_single_timeout: rx_valid=%b want 1 within 20 cycles", o_rx_valid);
        end
        check_rx("rx_single", 8'hA5, 1'b1);
        repeat (H - 1) @(negedge wb_clk);
        park();
        check_rx("rx_single_hold", 8'hA5, 1'b1);
        total++;
        if (valid_rises - r0 !== 1) begin
            bad++;
            $display("FAIL rx_single_once: valid rises=%0d want 1", valid_rises - r0);
        end
        pop("rx_single");
    endtask

    task automatic test_rx_random();
        logic [7:0] d;
        logic       s;
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            s = 1'($urandom);
            send_frame(d, s);
            check_rx("rx_random", d, s);
            pop("rx_random");
        end
    endtask

    task automatic test_tx();
        logic [12:1] samp, rdy;
        logic [7:0]  d;
        tx_offer(8'h3C, "tx_single");
        run_cycles(1'b0, 8'h00, 1'b0, samp, rdy);
        check_tx("tx_single", 8'h3C, samp, rdy);
        park();
        for (int n = 0; n < 3; n++) begin
            d = 8'($urandom);
            tx_offer(d, "tx_random");
            run_cycles(1'b0, 8'h00, 1'b0, samp, rdy);
            check_tx("tx_random", d, samp, rdy);
            park();
        end
    endtask

    task automatic test_duplex();
        logic [12:1] samp, rdy;
        logic [7:0]  rd, td;
        logic        rs;
        for (int n = 0; n < 3; n++) begin
            rd = (n == 0) ? 8'h55 : 8'($urandom);
            td = (n == 0) ? 8'hF0 : 8'($urandom);
            rs = 1'($urandom);
            tx_offer(td, "duplex");
            run_cycles(1'b1, rd, rs, samp, rdy);
            park();
            check_tx("duplex", td, samp, rdy);
            check_rx("duplex", rd, rs);
            pop("duplex");
        end
    endtask

    task automatic test_overrun();
        logic s1, s2;
        s1 = 1'($urandom);
        s2 = ~s1;
        send_frame(8'h11, s1);
        send_frame(8'h22, s2);
        check_rx("overrun_keep", 8'h11, s1);
`ifdef FSSER_OVERRUN_EN
        total++;
        if ({o_overrun, o_drop_cnt} !== {1'b1, 16'd1}) begin
            bad++;
            $display("FAIL overrun_flag: overrun=%b cnt=%0d want 1,1", o_overrun, o_drop_cnt);
        end
        @(negedge wb_clk);
        i_overrun_clr = 1'b1;
        @(negedge wb_clk);
        i_overrun_clr = 1'b0;
        total++;
        if ({o_overrun, o_drop_cnt} !== 17'd0) begin
            bad++;
            $display("FAIL overrun_clear: overrun=%b cnt=%0d want 0,0", o_overrun, o_drop_cnt);
        end
`endif
        pop("overrun");
    endtask

    task automatic test_pop_load();
        logic [7:0] d1, d2;
        logic       s1, s2, so;
        int         r0;
        d1 = 8'($urandom);
        d2 = ~d1;
        s1 = 1'($urandom);
        s2 = 1'($urandom);
        send_frame(d1, s1);
        check_rx("pop_load_first", d1, s1);
        r0 = valid_rises;
        for (int i = 0; i < 9; i++) clk_bit(frame_bit(d2, s2, i), so);
        clk_bit_hi(frame_bit(d2, s2, 9), so);
        if (rx_lat <= 1) i_rx_ready = 1'b1;
        for (int k = 1; k <= rx_lat; k++) begin
            @(negedge wb_clk);
            if (k == rx_lat - 1) i_rx_ready = 1'b1;
        end
        i_rx_ready = 1'b0;
        check_rx("pop_load_second", d2, s2);
        repeat (H) @(negedge wb_clk);
        park();
        total++;
        if (valid_rises - r0 !== 0) begin
            bad++;
            $display("FAIL pop_load_no_bubble: valid rises=%0d want 0", valid_rises - r0);
        end
        pop("pop_load");
    endtask

    task automatic test_reset_mid_tx();
        logic [12:1] samp, rdy;
        logic [5:1]  got, e;
        logic        so;
        tx_offer(8'h81, "rst_tx");
        for (int k = 1; k <= 5; k++) begin
            clk_bit(1'b1, so);
            got[k] = so;
        end
        e[1] = 1'b1;
        for (int k = 2; k <= 5; k++) e[k] = frame_bit(8'h81, 1'b1, k - 2);
        total++;
        if (got !== e || o_fsdo !== 1'b0) begin
            bad++;
            $display("FAIL rst_tx_pre: samples=%b fsdo=%b want %b,0", got, o_fsdo, e);
        end
        wb_rst = 1'b1;
        @(negedge wb_clk);
        total++;
        if ({o_fsdo, o_tx_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rst_tx_abort: fsdo,ready=%b want 10", {o_fsdo, o_tx_ready});
        end
        i_fsclk = 1'b0;
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        total++;
        if (o_tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_tx_release: tx_ready=%b want 1", o_tx_ready);
        end
        park();
        tx_offer(8'h81, "rst_tx_fresh");
        run_cycles(1'b0, 8'h00, 1'b0, samp, rdy);
        check_tx("rst_tx_fresh", 8'h81, samp, rdy);
        park();
    endtask

    initial begin
        test_reset();
        park();
        test_rx_single();
        test_rx_random();
        test_tx();
        test_duplex();
        test_overrun();
        test_pop_load();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
